// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder : req/ack data-memory responder with programmable wait states
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_DMR_req,
  input  logic        i_DMR_we,
  input  logic        i_DMR_sByte,
  input  logic [31:0] i_DMR_addr,
  input  logic [31:0] i_DMR_wdata,
  output logic        o_DMR_busy,
  output logic        o_DMR_ack,
  output logic [31:0] o_DMR_rdata,
  output logic        o_DMR_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        we_q;
  logic        byte_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [2**ADDR_W];

  logic [31:0]       op_addr;
  logic              op_we;
  logic              op_byte;
  logic [31:0]       op_wdata;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              fault;
  logic              commit;
  logic              wr_en;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [31:0]       wr_word;
  logic [31:0]       resp_data;

  // With zero wait states the commit happens on the acceptance edge, so the
  // live request operands are used instead of the latched copy.
  always_comb begin
    op_addr  = (state == IDLE) ? i_DMR_addr  : addr_q;
    op_we    = (state == IDLE) ? i_DMR_we    : we_q;
    op_byte  = (state == IDLE) ? i_DMR_sByte : byte_q;
    op_wdata = (state == IDLE) ? i_DMR_wdata : wdata_q;
    idx      = op_addr[ADDR_W+1:2];
    lane     = op_addr[1:0];
    fault    = (!op_byte && (lane != 2'd0)) || ((op_addr >> (ADDR_W + 2)) != 32'd0);
    commit   = ((state == IDLE) && i_DMR_req && (LAT == 4'd0)) ||
               ((state == WAIT) && (cnt == 4'd1));
    wr_en    = commit && op_we && !fault && !rst;
    rd_word  = mem[idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    wr_word  = op_wdata;
    if (op_byte) begin
      wr_word = rd_word;
      wr_word[{lane, 3'b000} +: 8] = op_wdata[7:0];
    end
    resp_data = 32'd0;
    if (!fault && !op_we)
      resp_data = op_byte ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
  end

  // RAM is deliberately outside the reset domain: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      wdata_q     <= 32'd0;
      o_DMR_busy  <= 1'b0;
      o_DMR_ack   <= 1'b0;
      o_DMR_rdata <= 32'd0;
      o_DMR_err   <= 1'b0;
    end else begin
      o_DMR_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_DMR_req) begin
            addr_q     <= i_DMR_addr;
            we_q       <= i_DMR_we;
            byte_q     <= i_DMR_sByte;
            wdata_q    <= i_DMR_wdata;
            cnt        <= LAT;
            o_DMR_busy <= 1'b1;
            if (LAT != 4'd0) begin
              state <= WAIT;
            end else begin
              state       <= DONE;
              o_DMR_ack   <= 1'b1;
              o_DMR_rdata <= resp_data;
              o_DMR_err   <= fault;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= DONE;
            o_DMR_ack   <= 1'b1;
            o_DMR_rdata <= resp_data;
            o_DMR_err   <= fault;
          end
        end
        DONE: begin
          state      <= IDLE;
          o_DMR_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          o_DMR_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder : scoreboard bench for dmem_responder (LATENCY 2 and 0)
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req2, we2, sb2, busy2, ack2, err2;
  logic [31:0] addr2, wd2, rd2;
  logic        req0, we0, sb0, busy0, ack0, err0;
  logic [31:0] addr0, wd0, rd0;

  dmem_responder #(.ADDR_W(AW), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .i_DMR_req(req2), .i_DMR_we(we2), .i_DMR_sByte(sb2),
    .i_DMR_addr(addr2), .i_DMR_wdata(wd2), .o_DMR_busy(busy2), .o_DMR_ack(ack2),
    .o_DMR_rdata(rd2), .o_DMR_err(err2));

  dmem_responder #(.ADDR_W(AW), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .i_DMR_req(req0), .i_DMR_we(we0), .i_DMR_sByte(sb0),
    .i_DMR_addr(addr0), .i_DMR_wdata(wd0), .o_DMR_busy(busy0), .o_DMR_ack(ack0),
    .o_DMR_rdata(rd0), .o_DMR_err(err0));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  logic [31:0] model [int unsigned];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ack = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference: byte-addressed memory as a map of words, one map region per DUT.
  function automatic exp_t ref_access(bit sel, bit we, bit byt, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int unsigned key;
    int lane;
    logic [31:0] w;
    logic [7:0] b;
    e.rdata = 32'd0; e.err = 1'b0; e.chk = 1'b1;
    if ((!byt && (a % 4 != 0)) || (a >= (32'd1 << (AW + 2)))) begin
      e.err = 1'b1;
      return e;
    end
    key  = (sel ? 32'h0100_0000 : 32'd0) + a / 4;
    lane = int'(a % 4);
    if (model.exists(key)) w = model[key];
    else begin w = 'x; e.chk = we; end
    if (we) begin
      if (byt) w = (w & ~(32'hFF << (8 * lane))) | ({24'd0, wd[7:0]} << (8 * lane));
      else w = wd;
      model[key] = w;
    end else if (byt) begin
      b = 8'(w >> (8 * lane));
      e.rdata = b[7] ? {24'hFFFFFF, b} : {24'h000000, b};
    end else begin
      e.rdata = w;
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon2
    exp_t e;
    if (ack2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack2_unexpected: actual=ack required=no ack");
      end else begin
        e = q2.pop_front();
        check("err_lat2", {31'd0, err2}, {31'd0, e.err});
        if (e.chk) check("rdata_lat2", rd2, e.rdata);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack0_unexpected: actual=ack required=no ack");
      end else begin
        e = q0.pop_front();
        check("err_lat0", {31'd0, err0}, {31'd0, e.err});
        if (e.chk) check("rdata_lat0", rd0, e.rdata);
      end
    end
  end

  // Called at a negedge; returns at the ack negedge (or one IDLE cycle later if drop).
  task automatic issue(input bit sel, input bit we, input bit byt, input logic [31:0] a,
                       input logic [31:0] wd, input bit drop);
    int n;
    bit got;
    int lat;
    lat = sel ? 0 : 2;
    if (sel) begin req0 = 1; we0 = we; sb0 = byt; addr0 = a; wd0 = wd; q0.push_back(ref_access(sel, we, byt, a, wd)); end
    else     begin req2 = 1; we2 = we; sb2 = byt; addr2 = a; wd2 = wd; q2.push_back(ref_access(sel, we, byt, a, wd)); end
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = sel ? (busy0 || ack0) : (busy2 || ack2);
    end
    check("accepted", {31'd0, got}, 32'd1);
    n = 1;
    while (1) begin
      check("busy_during_access", {31'd0, sel ? busy0 : busy2}, 32'd1);
      if (sel ? ack0 : ack2) break;
      if (n >= 40) break;
      @(negedge clk);
      n++;
    end
    check("ack_latency", 32'(n), 32'(lat + 1));
    last_ack = cyc;
    if (sel) req0 = 0; else req2 = 0;
    if (drop) begin
      @(negedge clk);
      check("busy_after_ack", {31'd0, sel ? busy0 : busy2}, 32'd0);
      check("ack_one_cycle", {31'd0, sel ? ack0 : ack2}, 32'd0);
    end
  endtask

  task automatic random_ops(input bit sel, input int count);
    int r;
    bit byt, we, drop;
    logic [31:0] a;
    for (int k = 0; k < count; k++) begin
      r = $urandom_range(0, 9);
      byt = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if (r == 0) a = (32'd1 << $urandom_range(12, 31)) | ($urandom_range(0, 15) * 4);
      else if (r == 1 && !byt) a = $urandom_range(0, 16) * 4 + $urandom_range(1, 3);
      else a = $urandom_range(0, 16) * 4 + (byt ? $urandom_range(0, 3) : 0);
      drop = (k == count - 1) || ($urandom_range(0, 3) != 0);
      issue(sel, we, byt, a, $urandom, drop);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t1;
    rst = 1;
    req2 = 0; we2 = 0; sb2 = 0; addr2 = 0; wd2 = 0;
    req0 = 0; we0 = 0; sb0 = 0; addr0 = 0; wd0 = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy2}, 32'd0);
    check("rst_ack", {31'd0, ack2}, 32'd0);
    check("rst_rdata", rd2, 32'd0);
    check("rst_err", {31'd0, err2}, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    rst = 0;
    @(negedge clk);

    for (int w = 0; w <= 16; w++) begin
      issue(0, 1, 0, 32'(w * 4), (w == 16) ? 32'd0 : $urandom, 1);
      issue(1, 1, 0, 32'(w * 4), $urandom, 1);
    end

    issue(0, 1, 0, 32'h10, 32'hDEADBEEF, 1);
    issue(0, 0, 0, 32'h10, 32'h0, 1);
    check("load_deadbeef", rd2, 32'hDEADBEEF);

    issue(0, 1, 0, 32'h20, 32'h11223344, 1);
    issue(0, 1, 1, 32'h21, 32'hFFFFFFAA, 1);
    issue(0, 0, 0, 32'h20, 32'h0, 1);
    check("lane_word", rd2, 32'h1122AA44);
    issue(0, 0, 1, 32'h21, 32'h0, 1);
    check("lane_byte1", rd2, 32'hFFFFFFAA);
    issue(0, 0, 1, 32'h23, 32'h0, 1);
    check("lane_byte3", rd2, 32'h00000011);

    issue(0, 1, 0, 32'h0, 32'hCAFEF00D, 1);
    issue(0, 0, 0, 32'h22, 32'h0, 1);
    check("misalign_err", {31'd0, err2}, 32'd1);
    check("misalign_rdata", rd2, 32'd0);
    issue(0, 1, 0, 32'h1000, 32'h55, 1);
    check("range_err", {31'd0, err2}, 32'd1);
    issue(0, 0, 0, 32'h0, 32'h0, 1);
    check("range_nowrite", rd2, 32'hCAFEF00D);

    issue(0, 1, 0, 32'h30, 32'hA5A5_0001, 0);
    t1 = last_ack;
    issue(0, 0, 0, 32'h30, 32'h0, 1);
    check("b2b_gap", 32'(last_ack - t1), 32'd4);

    req2 = 1; we2 = 1; sb2 = 0; addr2 = 32'h40; wd2 = 32'h12345678;
    @(negedge clk);
    check("abort_busy", {31'd0, busy2}, 32'd1);
    rst = 1; req2 = 0;
    @(negedge clk);
    rst = 0;
    check("abort_busy_clr", {31'd0, busy2}, 32'd0);
    check("abort_ack", {31'd0, ack2}, 32'd0);
    check("abort_rdata", rd2, 32'd0);
    check("abort_err", {31'd0, err2}, 32'd0);
    repeat (5) @(negedge clk);
    issue(0, 0, 0, 32'h40, 32'h0, 1);
    check("abort_nowrite", rd2, 32'd0);

    issue(1, 1, 0, 32'h8, 32'h0BADC0DE, 1);
    issue(1, 0, 0, 32'h8, 32'h0, 1);
    check("lat0_load", rd0, 32'h0BADC0DE);

    random_ops(0, 50);
    random_ops(1, 30);

    repeat (3) @(negedge clk);
    check("q2_drained", 32'(q2.size()), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the CPU MEM stage's load/store requests over a req/ack handshake. It is the memory-side end of the CPU data port. It accepts one word or byte access at a time, inserts a programmable number of wait states, then completes the access. Completion is a one-cycle acknowledge carrying read data and an error flag, and the pipeline stalls on `o_DMR_busy`. It owns a single-port word-organised RAM of 2^ADDR_W words.

## Interface
- `ADDR_W`, default 10: word-address width; RAM depth is 2^ADDR_W words (byte space 2^(ADDR_W+2)).
- `LATENCY`, default 2: wait-state cycles inserted before completion; legal range 0..15.

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `i_DMR_req`  in  1: request valid.
- `i_DMR_we`  in  1: 1 = store, 0 = load.
- `i_DMR_sByte`  in  1: 1 = byte access, 0 = word access.
- `i_DMR_addr`  in  32: byte address.
- `i_DMR_wdata`  in  32: store data; byte stores use bits [7:0].
- `o_DMR_busy`  out  1: responder is not IDLE; the initiator must stall.
- `o_DMR_ack`  out  1: one-cycle completion pulse.
- `o_DMR_rdata`  out  32: load result; valid with ack and held until the next ack.
- `o_DMR_err`  out  1: access faulted; valid with ack and held until the next ack.

## Operation
- FSM states: IDLE, WAIT, DONE. A 4-bit wait counter is used.
- **IDLE**
  - If `i_DMR_req`=1 at the edge, latch addr, we, sByte and wdata, and load the counter with LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise DONE.
  - `req` is ignored in WAIT and DONE. Input changes after acceptance have no effect.
- **WAIT**
  - The counter decrements each cycle.
  - When the counter equals 1 at the edge, go to DONE and commit the access on that edge.
- **DONE**
  - `o_DMR_ack`=1 for exactly this cycle.
  - Next state is always IDLE.
- **Access commit** (the edge entering DONE):
  - Fault check: a word access with addr[1:0]≠0, or any access with addr[31:ADDR_W+2]≠0.
  - On a fault: RAM is not modified, rdata=0, err=1.
  - Word load: rdata = RAM[addr[ADDR_W+1:2]].
  - Word store: write all 32 bits; rdata=0.
  - Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0], 3 selects bits [31:24].
  - Byte load: the selected byte, sign-extended to 32 bits.
  - Byte store: replace only the selected lane with wdata[7:0]; other lanes are unchanged; rdata=0.
  - err=0 for every non-faulting access.
- `o_DMR_busy` is a registered output, equal to (state≠IDLE).
- The RAM array is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, busy 0, ack 0, rdata 0, err 0.
- Request accepted at edge t:
  - busy=1 from cycle t+1.
  - ack is high in cycle t+1+LATENCY.
  - busy falls in the cycle after ack.
- Handshake:
  - The initiator holds req and its operands stable until the ack cycle, inclusive.
  - The initiator drops req in the following IDLE cycle unless it is issuing a new request.
  - A req still high in that IDLE cycle is a new request.
- Throughput: at most one access per LATENCY+2 cycles. At least one IDLE cycle separates ack from the next acceptance.
- LATENCY=0: ack arrives in the cycle after acceptance; busy is high only in that DONE cycle.
- Reset mid-operation:
  - `rst` high at any edge forces all reset values.
  - A store whose commit edge coincides with or follows `rst` does not modify RAM.
  - No ack is issued for an aborted request.
- `rst` and `req` high on the same edge: reset wins and the request is dropped.

## Test plan
- **Word store/load, LATENCY=2:** store 0xDEADBEEF to 0x10, then load 0x10. Each request gets ack exactly 3 cycles after acceptance, with busy high for 3 cycles. The load returns rdata=0xDEADBEEF, err=0.
- **Byte lanes:** after word 0x11223344 at 0x20, byte-store 0xAA to 0x21. Word load of 0x20 returns 0x1122AA44. Byte load of 0x21 returns 0xFFFFFFAA. Byte load of 0x23 returns 0x00000011.
- **Faults:** word load of 0x22 acks with err=1, rdata=0. Word store of 0x55 to 0x1000 (out of range with ADDR_W=10) acks with err=1 and does not modify 0x0000.
- **Back-to-back with req held high after ack:** a second request is accepted in the IDLE cycle following ack. Two acks are 4 cycles apart at LATENCY=2.
- **Reset mid-store:** store 0x12345678 to 0x40 with `rst` pulsed in the WAIT cycle. There is no ack, and all outputs go to 0 next cycle. A later load of 0x40 returns the previous contents (0x0 if 0x0 was written earlier).
- **LATENCY=0 build:** ack in the cycle immediately after acceptance. Load data is correct, and busy is high for exactly 1 cycle.
